bitserial_alu_ctrl: RTL
=======================

Name: bitserial_alu_ctrl

Overview:
- Sequencer that drives one external 1-bit ALU bitslice (AND/OR/full-add) over WIDTH clock cycles to perform a WIDTH-bit operation, LSB first.
- Latches operands on a start pulse, feeds one bit pair per cycle with the running carry, and shifts slice results into a result register.
- Flags completion with a one-cycle done pulse.
- Sits between the datapath register file/control and the alu_bitslice instance; it owns all sequencing of the slice.

Parameters:
- WIDTH, 8, operand/result width in bits (>= 2).
- CNT_W, 3, bit-counter width; must equal ceil(log2(WIDTH)).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op  input  2  operation: 00 AND, 01 OR, 10 ADD, 11 SUB (a-b).
- a  input  WIDTH  operand A; latched on accepted start.
- b  input  WIDTH  operand B; latched on accepted start.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse when the result is valid.
- result  output  WIDTH  final result; held stable from done until the next accepted start.
- cout  output  1  final carry for ADD/SUB (SUB: 1 = no borrow); 0 for AND/OR.
- zero  output  1  result == 0; valid with result.
- slice_a  output  1  current A bit to the slice.
- slice_b  output  1  current B bit to the slice; inverted for SUB.
- slice_cin  output  1  running carry to the slice.
- slice_op  output  2  slice function: 00 AND, 01 OR, 10 SUM.
- slice_out  input  1  slice result bit (combinational from slice_* outputs).
- slice_cout  input  1  slice carry out.

Behaviour:
- Reset (async, any state, including mid-operation): state = IDLE; busy, done, cout, zero = 0; result = 0; counter, operand shift registers and carry = 0; slice_* outputs = 0. Any operation in flight is discarded.
- IDLE: busy = 0. On start = 1 at an edge:
  - latch a and b into shift registers and op into an op register;
  - carry = 1 if op = SUB, else 0; counter = 0; go to RUN.
- RUN (exactly WIDTH cycles):
  - slice_a = A shift-reg bit 0; slice_b = B bit 0 XOR (op == SUB); slice_cin = carry; slice_op derived from op (ADD/SUB -> 10).
  - Each edge: result shifts right with slice_out entering at bit WIDTH-1; A and B shift right; carry = slice_cout for ADD/SUB, forced 0 for AND/OR; counter increments.
  - On the edge where counter = WIDTH-1: cout = final carry, zero = (new result == 0), go to DONE.
- DONE: done = 1 for exactly one cycle, then return to IDLE.
- Latency: start accepted at edge T -> done high during the cycle following edge T+WIDTH. WIDTH=8 gives 9 cycles start-to-done.
- start while busy (RUN or DONE) is ignored and not queued. A start held high continuously restarts in the first IDLE cycle after DONE.
- a, b and op may change freely after acceptance.
- Arithmetic is modulo 2^WIDTH; overflow is not flagged.
- The slice path is combinational; its outputs are captured only on clk edges inside RUN.

Decomposition:
- Shared include (alu_defs.vh):
  - op encodings OP_AND/OP_OR/OP_ADD/OP_SUB;
  - slice function codes;
  - state encodings S_IDLE/S_RUN/S_DONE.
- Sub-module alu_bitslice (1-bit AND/OR/full-add, built from the existing gate primitives) is instantiated by the enclosing top, bitserial_alu, alongside this controller. The controller itself contains no slice logic.
- The bench tests bitserial_alu and the controller alone (with a behavioural slice model).

Test Plan:
- ADD a=8'h3C, b=8'h05, start 1 cycle -> done 9 cycles later; result=8'h41, cout=0, zero=0; busy high for 9 cycles.
- SUB a=8'h05, b=8'h06 -> result=8'hFF, cout=0 (borrow); SUB a=8'h06, b=8'h05 -> result=8'h01, cout=1.
- ADD a=8'hFF, b=8'h01 -> result=8'h00, cout=1, zero=1. AND 8'hF0 & 8'h3C -> 8'h30, cout=0. OR 8'hF0 | 8'h0F -> 8'hFF.
- start re-pulsed with a=8'h00 during RUN (cycle 4) -> ignored; first result is unchanged and exactly one done pulse occurs. start held high -> back-to-back operations, one done per 10 cycles.
- rst asserted asynchronously mid-RUN (between edges) -> busy, done, result, cout and zero go to 0 immediately. After release, a new ADD 8'h01+8'h01 gives 8'h02.

Source files
------------

// File: rtl/bitserial_alu_ctrl_pkg.sv
// Shared encodings for the bit-serial ALU sequencer: operations, slice
// function codes and controller states.
package bitserial_alu_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    SL_AND = 2'b00,
    SL_OR  = 2'b01,
    SL_SUM = 2'b10
  } slice_fn_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  // ADD and SUB share the slice adder and propagate carry; AND/OR do not.
  function automatic logic op_is_arith(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic [1:0] slice_fn(input logic [1:0] op);
    return op[1] ? SL_SUM : {1'b0, op[0]};
  endfunction

endpackage

// File: rtl/bitserial_alu_ctrl_if.sv
// Request/response bus plus the bitslice connection of the bit-serial ALU
// sequencer. master = requester and slice side, slave = sequencer.
interface bitserial_alu_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             zero;
  logic             slice_a;
  logic             slice_b;
  logic             slice_cin;
  logic [1:0]       slice_op;
  logic             slice_out;
  logic             slice_cout;

  modport master (
    output start, op, a, b, slice_out, slice_cout,
    input  busy, done, result, cout, zero,
    input  slice_a, slice_b, slice_cin, slice_op
  );

  modport slave (
    input  start, op, a, b, slice_out, slice_cout,
    output busy, done, result, cout, zero,
    output slice_a, slice_b, slice_cin, slice_op
  );
endinterface

// File: rtl/bitserial_alu_ctrl_dp.sv
// Operand/result shift registers and running carry of the bit-serial ALU.
// Loaded on an accepted start, shifted once per RUN cycle.
module bitserial_alu_ctrl_dp
  import bitserial_alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic             i_last,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_slice_out,
  input  logic             i_slice_cout,
  output logic [1:0]       o_op,
  output logic             o_a0,
  output logic             o_b0,
  output logic             o_carry,
  output logic [WIDTH-1:0] o_result,
  output logic             o_cout,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [1:0]       r_op;
  logic             r_carry;
  logic             r_cout;
  logic             r_zero;

  logic [WIDTH-1:0] w_res_nxt;
  logic             w_carry_nxt;

  assign w_res_nxt   = {i_slice_out, r_res[WIDTH-1:1]};
  assign w_carry_nxt = op_is_arith(r_op) & i_slice_cout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_op    <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_zero  <= 1'b0;
    end else if (i_load) begin
      r_a     <= i_a;
      r_b     <= i_b;
      r_op    <= i_op;
      // SUB is a + ~b + 1: the +1 enters as the initial carry.
      r_carry <= (i_op == OP_SUB);
    end else if (i_shift) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_res   <= w_res_nxt;
      r_carry <= w_carry_nxt;
      if (i_last) begin
        r_cout <= w_carry_nxt;
        r_zero <= (w_res_nxt == '0);
      end
    end
  end

  assign o_op     = r_op;
  assign o_a0     = r_a[0];
  assign o_b0     = r_b[0] ^ (r_op == OP_SUB);
  assign o_carry  = r_carry;
  assign o_result = r_res;
  assign o_cout   = r_cout;
  assign o_zero   = r_zero;

endmodule

// File: rtl/bitserial_alu_ctrl.sv
// Sequencer for an external 1-bit ALU slice: runs a WIDTH-bit AND/OR/ADD/SUB
// LSB-first over WIDTH cycles, then pulses done for one cycle.
module bitserial_alu_ctrl
  import bitserial_alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  bitserial_alu_ctrl_if.slave  bus
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;

  logic             w_load;
  logic             w_shift;
  logic             w_last;
  logic             w_busy;
  logic             w_done;

  logic [1:0]       w_op;
  logic             w_a0;
  logic             w_b0;
  logic             w_carry;

  assign w_last = w_shift && (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last)    w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_load  = 1'b0;
    w_shift = 1'b0;
    w_busy  = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      S_IDLE: w_load = bus.start;
      S_RUN: begin
        w_shift = 1'b1;
        w_busy  = 1'b1;
      end
      S_DONE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_cnt <= '0;
    else if (w_load)  r_cnt <= '0;
    else if (w_shift) r_cnt <= r_cnt + 1'b1;
  end

  bitserial_alu_ctrl_dp #(.WIDTH(WIDTH)) u_dp (
    .clk          (clk),
    .rst          (rst),
    .i_load       (w_load),
    .i_shift      (w_shift),
    .i_last       (w_last),
    .i_op         (bus.op),
    .i_a          (bus.a),
    .i_b          (bus.b),
    .i_slice_out  (bus.slice_out),
    .i_slice_cout (bus.slice_cout),
    .o_op         (w_op),
    .o_a0         (w_a0),
    .o_b0         (w_b0),
    .o_carry      (w_carry),
    .o_result     (bus.result),
    .o_cout       (bus.cout),
    .o_zero       (bus.zero)
  );

  // Slice inputs are quiet outside RUN so the slice never sees stale operands.
  assign bus.slice_a   = w_shift & w_a0;
  assign bus.slice_b   = w_shift & w_b0;
  assign bus.slice_cin = w_shift & w_carry;
  assign bus.slice_op  = w_shift ? slice_fn(w_op) : 2'b00;

  assign bus.busy = w_busy;
  assign bus.done = w_done;

endmodule
